// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: program sequencer for the combinational ALU.
// Fetches instruction words from a synchronous ROM, reads two operands from a
// synchronous-read RAM, presents them with the opcode to the ALU and writes the
// ALU result back to RAM. Instruction = {op[3:0], src1, src2, dst}.
module alu_seq_ctrl #(
  parameter int unsigned AW       = 4,
  parameter int unsigned PC_W     = 6,
  parameter int unsigned PROG_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              zf,
  output logic [PC_W-1:0]   irom_addr,
  input  logic [4+3*AW-1:0] irom_data,
  output logic [AW-1:0]     ram_raddr1,
  output logic [AW-1:0]     ram_raddr2,
  input  logic [31:0]       ram_rdata1,
  input  logic [31:0]       ram_rdata2,
  output logic              ram_we,
  output logic [AW-1:0]     ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        sel_op,
  output logic [31:0]       d_ROM1,
  output logic [31:0]       d_ROM2,
  input  logic [31:0]       s_ALU
);

  localparam int unsigned IW = 4 + 3 * AW;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_DIV  = 4'b0111;
  localparam logic [3:0] OP_MIN  = 4'b0100;
  localparam logic [3:0] OP_MAX  = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [31:0]     d_rom1_q, d_rom1_d;
  logic [31:0]     d_rom2_q, d_rom2_d;
  logic [3:0]      sel_op_q, sel_op_d;
  logic [31:0]     result_q, result_d;
  logic            wr_ok_q, wr_ok_d;
  logic            err_q, err_d;
  logic            zf_q, zf_d;

  // Instruction fields, both from the live ROM word (DECODE) and the latched copy
  logic [3:0]    rom_op;
  logic [AW-1:0] rom_src1, rom_src2;
  logic [3:0]    ins_op;
  logic [AW-1:0] ins_src1, ins_src2, ins_dst;

  logic op_legal;
  logic div_zero;

  assign rom_op   = irom_data[IW-1 -: 4];
  assign rom_src1 = irom_data[3*AW-1 -: AW];
  assign rom_src2 = irom_data[2*AW-1 -: AW];
  assign ins_op   = instr_q[IW-1 -: 4];
  assign ins_src1 = instr_q[3*AW-1 -: AW];
  assign ins_src2 = instr_q[2*AW-1 -: AW];
  assign ins_dst  = instr_q[AW-1:0];

  assign op_legal = (sel_op_q >= OP_MIN) && (sel_op_q <= OP_MAX);
  assign div_zero = (sel_op_q == OP_DIV) && (d_rom2_q == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      d_rom1_q <= '0;
      d_rom2_q <= '0;
      sel_op_q <= '0;
      result_q <= '0;
      wr_ok_q  <= 1'b0;
      err_q    <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      d_rom1_q <= d_rom1_d;
      d_rom2_q <= d_rom2_d;
      sel_op_q <= sel_op_d;
      result_q <= result_d;
      wr_ok_q  <= wr_ok_d;
      err_q    <= err_d;
      zf_q     <= zf_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (rom_op == OP_HALT) ? S_DONE : S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_WRITE;
      S_WRITE:  state_d = (pc_q == LAST_PC) ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath register updates per state
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    d_rom1_d = d_rom1_q;
    d_rom2_d = d_rom2_q;
    sel_op_d = sel_op_q;
    result_d = result_q;
    wr_ok_d  = wr_ok_q;
    err_d    = err_q;
    zf_d     = zf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d  = '0;
          err_d = 1'b0;
        end
      end
      S_DECODE: begin
        instr_d = irom_data;
      end
      S_READ: begin
        d_rom1_d = ram_rdata1;
        d_rom2_d = ram_rdata2;
        sel_op_d = ins_op;
      end
      S_EXEC: begin
        result_d = s_ALU;
        wr_ok_d  = op_legal && !div_zero;
        if (!(op_legal && !div_zero)) err_d = 1'b1;
      end
      S_WRITE: begin
        if (wr_ok_q) zf_d = (result_q == '0);
        // End-of-program test uses the pre-increment pc, so a full-size
        // program reaches DONE before the natural PC_W-bit wrap matters.
        pc_d = pc_q + PC_W'(1);
      end
      S_DONE: begin
        pc_d = '0;
      end
      default: ;
    endcase
  end

  // Output decode
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    ram_we     = (state_q == S_WRITE) && wr_ok_q;
    irom_addr  = pc_q;
    // Read addresses come straight from the ROM word in DECODE so the RAM
    // data is ready in READ; afterwards they hold the latched instruction.
    ram_raddr1 = (state_q == S_DECODE) ? rom_src1 : ins_src1;
    ram_raddr2 = (state_q == S_DECODE) ? rom_src2 : ins_src2;
    ram_waddr  = ins_dst;
    ram_wdata  = result_q;
    sel_op     = sel_op_q;
    d_ROM1     = d_rom1_q;
    d_ROM2     = d_rom2_q;
    err        = err_q;
    zf         = zf_q;
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ROM, RAM and ALU around the sequencer,
// with a reference executor that queues the expected RAM writes.
module tb_alu_seq_ctrl;

  localparam int unsigned AW       = 4;
  localparam int unsigned PC_W     = 6;
  localparam int unsigned PROG_LEN = 3;
  localparam int unsigned IW       = 4 + 3 * AW;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy, done, err, zf;
  logic [PC_W-1:0]   irom_addr;
  logic [IW-1:0]     irom_data;
  logic [AW-1:0]     ram_raddr1, ram_raddr2, ram_waddr;
  logic [31:0]       ram_rdata1, ram_rdata2, ram_wdata;
  logic              ram_we;
  logic [3:0]        sel_op;
  logic [31:0]       d_rom1, d_rom2, s_alu;

  alu_seq_ctrl #(.AW(AW), .PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err(err), .zf(zf), .irom_addr(irom_addr), .irom_data(irom_data),
    .ram_raddr1(ram_raddr1), .ram_raddr2(ram_raddr2),
    .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .sel_op(sel_op), .d_ROM1(d_rom1), .d_ROM2(d_rom2), .s_ALU(s_alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] rom [64];
  logic [31:0]   mem [16];

  always @(posedge clk) irom_data <= rom[irom_addr];

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata1 <= mem[ram_raddr1];
    ram_rdata2 <= mem[ram_raddr2];
  end

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd4:    return a + b;
      4'd5:    return a - b;
      4'd6:    return a * b;
      4'd7:    return (b == 0) ? 32'd0 : a / b;
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return ~(a & b);
      4'd11:   return ~(a | b);
      4'd12:   return a ^ b;
      4'd13:   return ~(a ^ b);
      default: return 32'd0;
    endcase
  endfunction

  always_comb s_alu = alu_ref(sel_op, d_rom1, d_rom2);

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int we_count = 0;
  int done_count = 0;
  logic exp_err = 1'b0;
  logic exp_zf  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every RAM write must match the head of the scoreboard
  always @(negedge clk) begin
    if (done) done_count++;
    if (ram_we) begin
      we_count++;
      if (sb.size() == 0) begin
        check_eq("unexpected_we", ram_we, 1'b0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check_eq("waddr", ram_waddr, e.addr);
        check_eq("wdata", ram_wdata, e.data);
      end
    end
  end

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [AW-1:0] s1,
                                       input logic [AW-1:0] s2, input logic [AW-1:0] d);
    return {op, s1, s2, d};
  endfunction

  // Reference executor: pushes expected writes, returns latency and write count
  task automatic model_run(output int lat, output int nwr);
    logic [31:0] m [16];
    logic [3:0]  op;
    logic [31:0] a, b, r;
    wr_t w;
    m = mem;
    lat = 0;
    nwr = 0;
    exp_err = 1'b0;
    for (int i = 0; i < int'(PROG_LEN); i++) begin
      op = rom[i][IW-1 -: 4];
      if (op == 4'd0) begin
        lat += 2;
        break;
      end
      lat += 5;
      a = m[rom[i][3*AW-1 -: AW]];
      b = m[rom[i][2*AW-1 -: AW]];
      if (op < 4'd4 || op > 4'd13 || (op == 4'd7 && b == 0)) begin
        exp_err = 1'b1;
      end else begin
        r = alu_ref(op, a, b);
        w.addr = rom[i][AW-1:0];
        w.data = r;
        sb.push_back(w);
        m[w.addr] = r;
        exp_zf = (r == 0);
        nwr++;
      end
    end
  endtask

  task automatic run_prog(input bit pulse_mid, output int cnt);
    int lat, nwr, we0;
    model_run(lat, nwr);
    we0 = we_count;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    check_eq("busy_after_start", busy, 1'b1);
    check_eq("err_cleared", err, 1'b0);
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk) #1 cnt++;
      if (pulse_mid && cnt == 2) start = 1'b1;
      if (pulse_mid && cnt == 3) start = 1'b0;
      if (done) break;
    end
    check_eq("done_seen", done, 1'b1);
    check_eq("latency", cnt, lat);
    // start raised during the DONE cycle must not relaunch
    start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    check_eq("start_in_done", busy, 1'b0);
    check_eq("err", err, exp_err);
    check_eq("zf", zf, exp_zf);
    check_eq("writes", we_count - we0, nwr);
    check_eq("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int cnt, we0, dn0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h0101_0101;
    #23;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_zf", zf, 1'b0);
    check_eq("rst_we", ram_we, 1'b0);
    check_eq("rst_irom_addr", irom_addr, 0);
    check_eq("rst_raddr", {ram_raddr1, ram_raddr2, ram_waddr}, 0);
    check_eq("rst_wdata", ram_wdata, 0);
    check_eq("rst_sel_op", sel_op, 0);
    check_eq("rst_drom", d_rom1 | d_rom2, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: add, then HALT
    mem[1] = 32'd7; mem[2] = 32'd5;
    rom[0] = mk(4'b0100, 1, 2, 3); rom[1] = '0; rom[2] = '0;
    run_prog(1'b0, cnt);
    check_eq("t1_ram3", mem[3], 32'd12);
    check_eq("t1_lat", cnt, 7);
    check_eq("t1_zf", zf, 1'b0);

    // 2: sub to zero, then mul
    mem[1] = 32'd9; mem[2] = 32'd9;
    rom[0] = mk(4'b0101, 1, 2, 4); rom[1] = '0;
    run_prog(1'b0, cnt);
    check_eq("t2_ram4", mem[4], 32'd0);
    check_eq("t2_zf1", zf, 1'b1);
    rom[0] = mk(4'b0110, 1, 2, 5);
    run_prog(1'b0, cnt);
    check_eq("t2_ram5", mem[5], 32'd81);
    check_eq("t2_zf0", zf, 1'b0);

    // 3: divide by zero suppressed, next instruction still runs
    mem[2] = 32'd0; mem[6] = 32'hDEAD;
    rom[0] = mk(4'b0111, 1, 2, 6); rom[1] = mk(4'b1100, 1, 1, 7); rom[2] = '0;
    run_prog(1'b0, cnt);
    check_eq("t3_ram6", mem[6], 32'hDEAD);
    check_eq("t3_ram7", mem[7], 32'd0);
    check_eq("t3_err", err, 1'b1);

    // 4: illegal opcode
    mem[8] = 32'h1234;
    rom[0] = mk(4'b0011, 1, 2, 8); rom[1] = '0;
    run_prog(1'b0, cnt);
    check_eq("t4_err", err, 1'b1);
    check_eq("t4_ram8", mem[8], 32'h1234);

    // 5: no HALT, program length limit
    mem[1] = 32'd7; mem[2] = 32'd5;
    rom[0] = mk(4'b0100, 1, 2, 9); rom[1] = mk(4'b1000, 1, 2, 10);
    rom[2] = mk(4'b1101, 1, 2, 11); rom[3] = mk(4'b0100, 1, 2, 12);
    run_prog(1'b0, cnt);
    check_eq("t5_lat", cnt, 15);
    check_eq("t5_pc0", irom_addr, 0);
    check_eq("t5_ram11", mem[11], 32'hFFFF_FFFD);

    // 6: reset during EXEC of instr0
    mem[12] = 32'h5555;
    rom[0] = mk(4'b0100, 1, 2, 12); rom[1] = '0;
    we0 = we_count; dn0 = done_count;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_we", ram_we, 1'b0);
    repeat (10) @(posedge clk);
    check_eq("t6_no_we", we_count - we0, 0);
    check_eq("t6_no_done", done_count - dn0, 0);
    check_eq("t6_ram12", mem[12], 32'h5555);
    @(negedge clk) rst_n = 1'b1;
    exp_zf = 1'b0;
    check_eq("t6_err_rst", err, 1'b0);
    run_prog(1'b1, cnt);
    check_eq("t6_ram12_run", mem[12], 32'd12);
    check_eq("t6_lat", cnt, 7);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
